// File: rtl/tlc_sout_capture.sv
`default_nettype none
// ============================================================================
// Module   : tlc_sout_capture
// Brief    : Monitors SCLK/LAT/SDO of a TLC data lane, reassembles each latched
//            word, classifies it, checks control words and keeps frame stats.
// Revision : 1.0 - initial release
// ============================================================================
module tlc_sout_capture #(
  parameter int LATCH_SIZE  = 769,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  localparam int c_BC_W     = $clog2(LATCH_SIZE + 2)
) (
  input  logic                  CLK_10M,
  input  logic                  RESET,
  input  logic                  SCLK_IN,
  input  logic                  LAT_IN,
  input  logic                  SDI,
  input  logic [LATCH_SIZE-1:0] EXP_CTRL,
  output logic [LATCH_SIZE-1:0] FRAME_DATA,
  output logic                  FRAME_VALID,
  output logic                  FRAME_IS_CTRL,
  output logic                  CTRL_MATCH,
  output logic                  FRAME_ERR,
  output logic [c_BC_W-1:0]     BIT_COUNT,
  output logic [CNT_W-1:0]      CTRL_FRAMES,
  output logic [CNT_W-1:0]      GS_FRAMES,
  output logic [CNT_W-1:0]      ERR_FRAMES
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CLOSE = 2'd2
  } state_t;

  localparam logic [c_BC_W-1:0] c_CNT_MAX = c_BC_W'(LATCH_SIZE + 1);
  localparam logic [c_BC_W-1:0] c_CNT_OK  = c_BC_W'(LATCH_SIZE);

  logic w_sclk, w_lat, w_sdi;

  // All three inputs share the same chain depth so bit/clock alignment holds.
  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] r_sclk_s, r_lat_s, r_sdi_s;
    always_ff @(posedge CLK_10M) begin
      if (RESET) begin
        r_sclk_s <= '0;
        r_lat_s  <= '0;
        r_sdi_s  <= '0;
      end else begin
        r_sclk_s[0] <= SCLK_IN;
        r_lat_s[0]  <= LAT_IN;
        r_sdi_s[0]  <= SDI;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          r_sclk_s[i] <= r_sclk_s[i-1];
          r_lat_s[i]  <= r_lat_s[i-1];
          r_sdi_s[i]  <= r_sdi_s[i-1];
        end
      end
    end
    assign w_sclk = r_sclk_s[SYNC_STAGES-1];
    assign w_lat  = r_lat_s[SYNC_STAGES-1];
    assign w_sdi  = r_sdi_s[SYNC_STAGES-1];
  end else begin : g_nosync
    assign w_sclk = SCLK_IN;
    assign w_lat  = LAT_IN;
    assign w_sdi  = SDI;
  end

  state_t                r_state;
  logic                  r_sclk_prev, r_lat_prev;
  logic [LATCH_SIZE-1:0] r_shreg;
  logic [c_BC_W-1:0]     r_bitcnt;

  logic                  w_sclk_rise, w_lat_rise, w_close, w_err, w_is_ctrl;
  logic [LATCH_SIZE-1:0] w_shreg_nxt;
  logic [c_BC_W-1:0]     w_bitcnt_nxt;

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_lat_rise  = w_lat & ~r_lat_prev;

  // A bit arriving with the latch edge belongs to the frame being closed.
  assign w_shreg_nxt  = w_sclk_rise ? {r_shreg[LATCH_SIZE-2:0], w_sdi} : r_shreg;
  assign w_bitcnt_nxt = !w_sclk_rise            ? r_bitcnt :
                        (r_bitcnt == c_CNT_MAX) ? r_bitcnt :
                                                  r_bitcnt + c_BC_W'(1);

  // An empty latch (no bits seen) never closes a frame.
  assign w_close   = w_lat_rise && (r_state != S_CLOSE) && (w_bitcnt_nxt != '0);
  assign w_err     = (w_bitcnt_nxt != c_CNT_OK);
  assign w_is_ctrl = w_shreg_nxt[LATCH_SIZE-1];

  always_ff @(posedge CLK_10M) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_sclk_prev   <= 1'b0;
      r_lat_prev    <= 1'b0;
      r_shreg       <= '0;
      r_bitcnt      <= '0;
      FRAME_DATA    <= '0;
      FRAME_VALID   <= 1'b0;
      FRAME_IS_CTRL <= 1'b0;
      CTRL_MATCH    <= 1'b0;
      FRAME_ERR     <= 1'b0;
      BIT_COUNT     <= '0;
      CTRL_FRAMES   <= '0;
      GS_FRAMES     <= '0;
      ERR_FRAMES    <= '0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_lat_prev  <= w_lat;
      FRAME_VALID <= 1'b0;
      if (w_close) begin
        // Results are registered on entry so they are valid during CLOSE.
        FRAME_DATA    <= w_shreg_nxt;
        BIT_COUNT     <= w_bitcnt_nxt;
        FRAME_VALID   <= 1'b1;
        FRAME_IS_CTRL <= w_is_ctrl;
        FRAME_ERR     <= w_err;
        CTRL_MATCH    <= !w_err && w_is_ctrl && (w_shreg_nxt == EXP_CTRL);
        if (w_err) begin
          if (ERR_FRAMES != {CNT_W{1'b1}}) ERR_FRAMES <= ERR_FRAMES + CNT_W'(1);
        end else if (w_is_ctrl) begin
          if (CTRL_FRAMES != {CNT_W{1'b1}}) CTRL_FRAMES <= CTRL_FRAMES + CNT_W'(1);
        end else begin
          if (GS_FRAMES != {CNT_W{1'b1}}) GS_FRAMES <= GS_FRAMES + CNT_W'(1);
        end
        r_shreg  <= '0;
        r_bitcnt <= '0;
        r_state  <= S_CLOSE;
      end else begin
        r_shreg  <= w_shreg_nxt;
        r_bitcnt <= w_bitcnt_nxt;
        r_state  <= (w_bitcnt_nxt != '0) ? S_SHIFT : S_IDLE;
      end
    end
  end

endmodule
`default_nettype wire
